// File: rtl/axi_pattern_responder.sv
// axi_pattern_responder
//   AXI4 target that answers host-initiated bursts with an address-derived
//   pattern. The 32-bit word at byte address A is A[31:0] ^ SEED. Read bursts
//   return the pattern. Write bursts are compared against it under wstrb.
//   Beat and error counters plus a sticky fail flag report the result.
//
// Ports
//   i_clk, nap_rstn        clock; asynchronous active-low reset
//   i_clear                synchronous clear of counters and o_fail
//   i_inject               one-shot rdata bit-0 corruption request
//                          (only when ACX_PATTERN_RSP_ERR_INJECT_EN is defined)
//   aw*/w*/b*              write address / data / response channels
//   ar*/r*                 read address / data channels
//   o_wr_beats, o_rd_beats accepted W beats / delivered R beats (wrap)
//   o_err_count, o_fail    mismatching W beats (saturating) / sticky flag
//
// Optional feature macro: ACX_PATTERN_RSP_ERR_INJECT_EN
module axi_pattern_responder #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 42,
  parameter int unsigned ID_WIDTH   = 8,
  parameter logic [31:0] SEED       = 32'h5A5A_0000
) (
  input  logic                    i_clk,
  input  logic                    nap_rstn,
  input  logic                    i_clear,
  input  logic                    i_inject,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [31:0]             o_wr_beats,
  output logic [31:0]             o_rd_beats,
  output logic [15:0]             o_err_count,
  output logic                    o_fail
);

  localparam int unsigned LANES  = DATA_WIDTH / 32;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [31:0]           w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_beat_q, w_beat_d;
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [31:0]           r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [31:0]           wr_beats_q, wr_beats_d;
  logic [31:0]           rd_beats_q, rd_beats_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  fail_q, fail_d;
  logic                  inj_armed_q, inj_armed_d;

  logic                  w_hs, r_hs, mismatch, data_err, len_err;
  logic [16:0]           err_sum;
  logic [DATA_WIDTH-1:0] w_pat;

  // Only address bits [31:5] feed the pattern; the rest are don't-care.
`ifdef ACX_PATTERN_RSP_ERR_INJECT_EN
  logic unused_bits;
  assign unused_bits = ^{awaddr[ADDR_WIDTH-1:32], awaddr[4:0],
                         araddr[ADDR_WIDTH-1:32], araddr[4:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{awaddr[ADDR_WIDTH-1:32], awaddr[4:0],
                         araddr[ADDR_WIDTH-1:32], araddr[4:0], i_inject};
`endif

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] base);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      p[32*k +: 32] = (base + 32'(4*k)) ^ SEED;
    end
    return p;
  endfunction

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bvalid ? w_id_q : '0;
  assign bresp   = 2'b00;

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rlast   = rvalid && (r_beat_q == r_len_q);
  assign rid     = rvalid ? r_id_q : '0;
  assign rresp   = 2'b00;
  assign rdata   = rvalid ? (pattern(r_addr_q) ^ {{(DATA_WIDTH-1){1'b0}}, inj_armed_q}) : '0;

  assign w_hs = wready && wvalid;
  assign r_hs = rvalid && rready;

  always_comb begin
    w_pat    = pattern(w_addr_q);
    mismatch = 1'b0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (wstrb[b] && (wdata[8*b +: 8] != w_pat[8*b +: 8])) mismatch = 1'b1;
    end
  end

  // wlast terminates the burst; a length disagreement with awlen is a
  // separate error, so one beat can add two to the error count.
  assign data_err = w_hs && mismatch;
  assign len_err  = w_hs && wlast && (w_beat_q != w_len_q);
  assign err_sum  = {1'b0, err_count_q} + {16'd0, data_err} + {16'd0, len_err};

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    unique case (w_state_q)
      W_IDLE: if (awvalid) begin
        w_state_d = W_DATA;
        w_id_d    = awid;
        w_addr_d  = {awaddr[31:5], 5'b0};
        w_len_d   = awlen;
        w_beat_d  = '0;
      end
      W_DATA: if (wvalid) begin
        w_addr_d = w_addr_q + 32'd32;
        w_beat_d = w_beat_q + 8'd1;
        if (wlast) w_state_d = W_RESP;
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    unique case (r_state_q)
      R_IDLE: if (arvalid) begin
        r_state_d = R_DATA;
        r_id_d    = arid;
        r_addr_d  = {araddr[31:5], 5'b0};
        r_len_d   = arlen;
        r_beat_d  = '0;
      end
      R_DATA: if (rready) begin
        r_addr_d = r_addr_q + 32'd32;
        r_beat_d = r_beat_q + 8'd1;
        if (r_beat_q == r_len_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_beats_d  = wr_beats_q + {31'd0, w_hs};
    rd_beats_d  = rd_beats_q + {31'd0, r_hs};
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    fail_d      = fail_q || data_err || len_err;
    if (i_clear) begin
      wr_beats_d  = '0;
      rd_beats_d  = '0;
      err_count_d = '0;
      fail_d      = 1'b0;
    end
  end

  // A pulse while armed is absorbed; delivery of the corrupted beat disarms.
  always_comb begin
`ifdef ACX_PATTERN_RSP_ERR_INJECT_EN
    inj_armed_d = inj_armed_q;
    if (r_hs && inj_armed_q) inj_armed_d = 1'b0;
    else if (i_inject)       inj_armed_d = 1'b1;
`else
    inj_armed_d = 1'b0;
`endif
  end

  always_ff @(posedge i_clk or negedge nap_rstn) begin
    if (!nap_rstn) begin
      w_state_q   <= W_IDLE;
      w_id_q      <= '0;
      w_addr_q    <= '0;
      w_len_q     <= '0;
      w_beat_q    <= '0;
      r_state_q   <= R_IDLE;
      r_id_q      <= '0;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_beat_q    <= '0;
      wr_beats_q  <= '0;
      rd_beats_q  <= '0;
      err_count_q <= '0;
      fail_q      <= 1'b0;
      inj_armed_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_addr_q    <= w_addr_d;
      w_len_q     <= w_len_d;
      w_beat_q    <= w_beat_d;
      r_state_q   <= r_state_d;
      r_id_q      <= r_id_d;
      r_addr_q    <= r_addr_d;
      r_len_q     <= r_len_d;
      r_beat_q    <= r_beat_d;
      wr_beats_q  <= wr_beats_d;
      rd_beats_q  <= rd_beats_d;
      err_count_q <= err_count_d;
      fail_q      <= fail_d;
      inj_armed_q <= inj_armed_d;
    end
  end

  assign o_wr_beats  = wr_beats_q;
  assign o_rd_beats  = rd_beats_q;
  assign o_err_count = err_count_q;
  assign o_fail      = fail_q;

endmodule

// File: tb/tb_axi_pattern_responder.sv
module tb_axi_pattern_responder;
  localparam int unsigned DW = 256;
  localparam int unsigned AW = 42;
  localparam int unsigned IW = 8;
  localparam logic [31:0] SEED = 32'h5A5A_0000;

  logic i_clk, nap_rstn, i_clear, i_inject;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [31:0] o_wr_beats, o_rd_beats;
  logic [15:0] o_err_count;
  logic o_fail;

  axi_pattern_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .SEED(SEED)) dut (
    .i_clk(i_clk), .nap_rstn(nap_rstn), .i_clear(i_clear), .i_inject(i_inject),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .o_wr_beats(o_wr_beats), .o_rd_beats(o_rd_beats), .o_err_count(o_err_count), .o_fail(o_fail)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Reference state: expected counters and the injection flag.
  longint unsigned exp_wr = 0, exp_rd = 0;
  int exp_err = 0;
  bit exp_fail = 0;
  bit inj_armed = 0;
  logic [31:0] cap_lane0, cap_lane7;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat n of a burst: 8 words, word k = ((addr rounded down to 32) + 32n + 4k) mod 2^32, XOR SEED.
  function automatic logic [255:0] model_beat(input logic [AW-1:0] addr, input int n);
    logic [255:0] v;
    longint unsigned base, a;
    logic [31:0] word;
    base = ((longint'(addr) / 32) * 32) + 32 * longint'(n);
    for (int k = 0; k < 8; k++) begin
      a = (base + 4 * longint'(k)) % 64'h1_0000_0000;
      word = 32'(a) ^ SEED;
      v[32*k +: 32] = word;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_counters();
    chk("wr_beats", o_wr_beats, 32'(exp_wr));
    chk("rd_beats", o_rd_beats, 32'(exp_rd));
    chk("err_count", o_err_count, 16'(exp_err));
    chk("fail", o_fail, exp_fail);
  endtask

  // One read and/or one write burst run cycle by cycle side by side.
  task automatic run(input bit rd_en, input logic [AW-1:0] raddr, input int rlen, input bit rnd_rdy,
                     input bit wr_en, input logic [AW-1:0] waddr, input int wlen, input int wlast_at,
                     input int bad_beat, input int bad_byte, input bit bad_strb, input int clear_beat);
    int rbeat, wbeat, wph, cyc, errs;
    bit rdone, rhs, whs, wl, clr;
    logic [IW-1:0] rid_v, wid_v;
    logic [255:0] e;
    rbeat = 0; wbeat = 0; wph = wr_en ? 0 : 2; cyc = 0; rdone = !rd_en;
    rid_v = IW'($urandom); wid_v = IW'($urandom);
    arvalid = rd_en; araddr = raddr; arlen = 8'(rlen); arid = rid_v;
    awvalid = wr_en; awaddr = waddr; awlen = 8'(wlen); awid = wid_v;
    if (rd_en) chk("arready_idle", arready, 1'b1);
    if (wr_en) chk("awready_idle", awready, 1'b1);
    step();
    arvalid = 0; awvalid = 0;
    while (!(rdone && wph == 2)) begin
      rhs = 0; whs = 0; wl = 0; clr = 0; errs = 0;
      wvalid = 0; wlast = 0; bready = 0; rready = 0;
      if (cyc++ > 3000) begin
        checks++; failures++;
        $error("FAIL timeout observed=%0d expected=done", cyc);
        break;
      end
      if (!rdone) begin
        e = model_beat(raddr, rbeat);
        if (inj_armed) e[0] = ~e[0];
        chk("rvalid", rvalid, 1'b1);
        chk("rdata", rdata, e);
        chk("rlast", rlast, rbeat == rlen);
        chk("rid", rid, rid_v);
        if (rbeat == 0) begin cap_lane0 = rdata[31:0]; cap_lane7 = rdata[255:224]; end
        rready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        rhs = rready;
      end
      if (wph == 0) begin
        chk("wready", wready, 1'b1);
        wvalid = ($urandom_range(0, 3) != 0);
        if (wvalid) begin
          wdata = model_beat(waddr, wbeat);
          wstrb = '1;
          if (wbeat == bad_beat) begin
            wdata[bad_byte*8 +: 8] = wdata[bad_byte*8 +: 8] ^ 8'hA5;
            wstrb[bad_byte] = bad_strb;
            if (bad_strb) errs++;
          end
          wl = (wbeat == wlast_at);
          wlast = wl;
          if (wl && wbeat != wlen) errs++;
          if (wbeat == clear_beat) clr = 1;
          whs = 1;
        end
      end else if (wph == 1) begin
        chk("bvalid", bvalid, 1'b1);
        chk("bid", bid, wid_v);
        chk("bresp", bresp, 2'b00);
        bready = 1;
      end
      i_clear = clr;
      step();
      i_clear = 0;
      if (clr) begin
        exp_wr = 0; exp_rd = 0; exp_err = 0; exp_fail = 0;
      end else begin
        exp_wr = (exp_wr + longint'(whs)) % 64'h1_0000_0000;
        exp_rd = (exp_rd + longint'(rhs)) % 64'h1_0000_0000;
        exp_err = (exp_err + errs > 65535) ? 65535 : exp_err + errs;
        if (errs > 0) exp_fail = 1;
      end
      if (rhs && inj_armed) inj_armed = 0;
      chk_counters();
      if (rhs) begin
        if (rbeat == rlen) begin
          chk("arready_after", arready, 1'b1);
          rdone = 1;
        end
        rbeat++;
      end
      if (whs) begin
        wbeat++;
        if (wl) wph = 1;
      end else if (wph == 1 && bready) begin
        chk("awready_after", awready, 1'b1);
        chk("bvalid_low", bvalid, 1'b0);
        wph = 2;
      end
    end
    wvalid = 0; wlast = 0; bready = 0; rready = 0;
  endtask

  logic [AW-1:0] ra, wa;

  initial begin
    nap_rstn = 0; i_clear = 0; i_inject = 0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 0; rready = 0;
    repeat (3) step();
    nap_rstn = 1;
    step();

    // Reset state
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_ids", {bid, rid}, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_resp", {bresp, rresp}, '0);
    chk_counters();

    // Basic read at 0x1000, 4 beats
    run(1, 42'h1000, 3, 0, 0, '0, 0, 0, -1, 0, 0, -1);
    chk("lane0_0x1000", cap_lane0, 32'h5A5A_1000);
    chk("lane7_0x1000", cap_lane7, 32'h5A5A_101C);
    chk("rd_beats_4", o_rd_beats, 32'd4);

    // Matching write at 0x2000, 8 beats
    run(0, '0, 0, 0, 1, 42'h2000, 7, 7, -1, 0, 0, -1);
    chk("wr_beats_8", o_wr_beats, 32'd8);

    // Wrong byte 5 on beat 2: masked, then enabled
    run(0, '0, 0, 0, 1, 42'h3000, 3, 3, 2, 5, 0, -1);
    run(0, '0, 0, 0, 1, 42'h3000, 3, 3, 2, 5, 1, -1);
    chk("err_after_mismatch", o_err_count, 16'd1);

    // Early and late wlast
    run(0, '0, 0, 0, 1, 42'h4000, 5, 2, -1, 0, 0, -1);
    run(0, '0, 0, 0, 1, 42'h5000, 2, 4, -1, 0, 0, -1);

    // Clear lands on the same cycle as a data error
    run(0, '0, 0, 0, 1, 42'h6000, 3, 3, 1, 9, 1, 1);

    // Read with backpressure alongside a matching write
    run(1, 42'h0_0000_7000, 15, 1, 1, 42'h0_0000_9000, 7, 7, -1, 0, 0, -1);

    // Address carry across bit 31, with high address bits set
    run(1, 42'h3_FFFF_FFC0, 3, 1, 1, 42'h2_FFFF_FFE4, 2, 2, -1, 0, 0, -1);

    // 256-beat read
    run(1, 42'h0_0010_0000, 255, 0, 0, '0, 0, 0, -1, 0, 0, -1);

    // Randomized concurrent traffic
    for (int i = 0; i < 6; i++) begin
      ra = {10'($urandom), 32'($urandom)};
      wa = {10'($urandom), 32'($urandom)};
      run(1, ra, $urandom_range(0, 15), 1, 1, wa, 5, 5,
          $urandom_range(0, 7), $urandom_range(0, 31), 1'($urandom_range(0, 1)), -1);
    end

    // Injection request
    i_inject = 1; step(); i_inject = 0;
`ifdef ACX_PATTERN_RSP_ERR_INJECT_EN
    inj_armed = 1;
    i_inject = 1; step(); i_inject = 0;
    run(1, '0, 1, 0, 0, '0, 0, 0, -1, 0, 0, -1);
    chk("inject_lane0", cap_lane0, 32'h5A5A_0001);
    run(1, '0, 0, 0, 0, '0, 0, 0, -1, 0, 0, -1);
    chk("inject_clean", cap_lane0, 32'h5A5A_0000);
`else
    run(1, '0, 1, 0, 0, '0, 0, 0, -1, 0, 0, -1);
    chk("inject_ignored", cap_lane0, 32'h5A5A_0000);
`endif

    // Reset during read beat 5 of 16
    arvalid = 1; araddr = 42'h8000; arlen = 8'd15; arid = 8'h3C;
    step();
    arvalid = 0; rready = 1;
    repeat (5) step();
    chk("mid_rvalid", rvalid, 1'b1);
    chk("mid_rdata", rdata, model_beat(42'h8000, 5));
    nap_rstn = 0;
    #1;
    chk("rst_mid_rvalid", rvalid, 1'b0);
    chk("rst_mid_arready", arready, 1'b1);
    chk("rst_mid_rd_beats", o_rd_beats, 32'd0);
    rready = 0;
    step();
    nap_rstn = 1;
    exp_wr = 0; exp_rd = 0; exp_err = 0; exp_fail = 0; inj_armed = 0;
    step();
    chk("post_rst_rvalid", rvalid, 1'b0);
    chk_counters();

    // Traffic resumes cleanly after the reset
    run(1, 42'h0_0000_A000, 2, 1, 1, 42'h0_0000_B000, 3, 3, -1, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
